// File: rtl/motion_pkg.sv
// Shared motion codes, direction indices and FSM state type for the motion scheduler.
// Pure definitions: no latency, no flow control.
package motion_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ARMED  = 2'd1,
      DELAY  = 2'd2,
      REPEAT = 2'd3
   } state_t;

   typedef logic [1:0] dir_t;

   localparam int NUM_DIR = 4;

   localparam int DIR_UP    = 0;
   localparam int DIR_RIGHT = 1;
   localparam int DIR_DOWN  = 2;
   localparam int DIR_LEFT  = 3;

   // Codes understood by the sprite position controller.
   localparam logic [2:0] MOT_NONE  = 3'd0;
   localparam logic [2:0] MOT_UP    = 3'd1;
   localparam logic [2:0] MOT_RIGHT = 3'd2;
   localparam logic [2:0] MOT_DOWN  = 3'd3;
   localparam logic [2:0] MOT_LEFT  = 3'd4;

   // Counter width able to hold 0..max_val-1, never narrower than one bit.
   function automatic int cnt_width(input int max_val);
      return (max_val <= 1) ? 1 : $clog2(max_val);
   endfunction

   // Round-robin pick: first requesting bit strictly after last, wrapping 3 -> 0.
   // Candidates are visited farthest-first so the nearest one wins.
   function automatic dir_t rr_pick(input logic [NUM_DIR-1:0] req, input dir_t last);
      dir_t pick;
      dir_t cand;
      pick = last;
      for (int i = NUM_DIR; i >= 1; i--) begin
         cand = last + dir_t'(i);
         if (req[cand]) pick = cand;
      end
      return pick;
   endfunction

   function automatic logic [2:0] dir_to_motion(input dir_t dir);
      return {1'b0, dir} + 3'd1;
   endfunction

endpackage

// File: rtl/motion_scheduler_debouncer.sv
// One button bit: 2-flop synchronizer plus a stability counter; stable output follows after 2+DEBOUNCE_CYC cycles.
// No flow control; the output simply tracks the filtered level.
module debouncer
   import motion_pkg::*;
#(
   parameter int DEBOUNCE_CYC = 250000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_raw,
   output logic stable
);

   localparam int CW = $clog2(DEBOUNCE_CYC + 1);
   // The count toggles the output on the cycle it would reach DEBOUNCE_CYC.
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

   logic [1:0]    sync_q;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q <= 2'b00;
         cnt    <= '0;
         stable <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], btn_raw};
         if (sync_q[1] == stable) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            stable <= ~stable;
            cnt    <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/motion_scheduler.sv
// Debounced buttons -> round-robin, frame-paced, auto-repeating single-cycle motion codes.
// motion is registered one cycle after the triggering frame_start; no backpressure, one pulse per issue.
module motion_scheduler
   import motion_pkg::*;
#(
   parameter int DEBOUNCE_CYC = 250000,
   parameter int REPEAT_DELAY = 30,
   parameter int REPEAT_RATE  = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] btn,
   input  logic       frame_start,
   output logic [2:0] motion
);

   localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int FW   = cnt_width(RMAX);
   localparam logic [FW-1:0] DELAY_LAST = FW'(REPEAT_DELAY - 1);
   localparam logic [FW-1:0] RATE_LAST  = FW'(REPEAT_RATE - 1);

   logic [NUM_DIR-1:0] stable;
   logic               held;
   state_t             state;
   state_t             state_nxt;
   logic [FW-1:0]      fcnt;
   logic [FW-1:0]      fcnt_nxt;
   dir_t               last_dir;
   dir_t               grant;
   logic               issue;

   for (genvar i = 0; i < NUM_DIR; i++) begin : g_deb
      debouncer #(
         .DEBOUNCE_CYC(DEBOUNCE_CYC)
      ) u_deb (
         .clk    (clk),
         .reset  (reset),
         .btn_raw(btn[i]),
         .stable (stable[i])
      );
   end

   assign held  = |stable;
   assign grant = rr_pick(stable, last_dir);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         fcnt     <= '0;
         last_dir <= dir_t'(DIR_LEFT);
         motion   <= MOT_NONE;
      end else begin
         state  <= state_nxt;
         fcnt   <= fcnt_nxt;
         motion <= issue ? dir_to_motion(grant) : MOT_NONE;
         if (issue) last_dir <= grant;
      end
   end

   // Release wins over everything, including a coincident frame_start.
   always_comb begin
      state_nxt = state;
      if (!held) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    state_nxt = ARMED;
            ARMED:   if (frame_start) state_nxt = DELAY;
            DELAY:   if (frame_start && fcnt == DELAY_LAST) state_nxt = REPEAT;
            default: state_nxt = state;
         endcase
      end
   end

   always_comb begin
      issue    = 1'b0;
      fcnt_nxt = fcnt;
      if (!held) begin
         fcnt_nxt = '0;
      end else if (frame_start) begin
         case (state)
            ARMED: begin
               issue    = 1'b1;
               fcnt_nxt = '0;
            end
            DELAY: begin
               if (fcnt == DELAY_LAST) begin
                  issue    = 1'b1;
                  fcnt_nxt = '0;
               end else begin
                  fcnt_nxt = fcnt + 1'b1;
               end
            end
            REPEAT: begin
               if (fcnt == RATE_LAST) begin
                  issue    = 1'b1;
                  fcnt_nxt = '0;
               end else begin
                  fcnt_nxt = fcnt + 1'b1;
               end
            end
            default: begin
               issue    = 1'b0;
               fcnt_nxt = fcnt;
            end
         endcase
      end
   end

endmodule

// File: doc/motion_scheduler.md
# motion_scheduler

Converts four raw direction buttons into single-cycle motion codes for the sprite position controller. It synchronizes and debounces the buttons, arbitrates round-robin between simultaneously held directions, and paces moves to frame boundaries with keyboard-style auto-repeat. It sits between the board button pins and the sprite controller's `motion` input, clocked with the VGA pixel clock.

## Interface
- `DEBOUNCE_CYC`, 250000: consecutive stable cycles required before a button change is accepted (10 ms at 25 MHz).
- `REPEAT_DELAY`, 30: frames between the first move and the first repeat.
- `REPEAT_RATE`, 4: frames between subsequent repeats.
- `clk` in 1: pixel clock. This is the only clock.
- `reset` in 1: asynchronous, active-low reset.
- `btn` in 4: raw buttons, asynchronous. Bit 0 = up, 1 = right, 2 = down, 3 = left.
- `frame_start` in 1: one-cycle pulse per frame, synchronous to `clk`, from the VGA timing block.
- `motion` out 3: move code. 000 = none, 001 = up, 010 = right, 011 = down, 100 = left. Registered.

## Operation
- **Synchronizer:** each `btn` bit passes through 2 flops.
- **Debounce:** each bit has its own counter, width `$clog2(DEBOUNCE_CYC+1)`.
  - When the synchronized value differs from the stable value, the counter increments.
  - When the counter reaches `DEBOUNCE_CYC`, the stable value toggles and the counter clears.
  - Any cycle where the synchronized value equals the stable value clears the counter.
- `held` = OR of the four stable bits.
- **FSM states:** IDLE, ARMED, DELAY, REPEAT. There is one frame counter, `fcnt`, with width `$clog2(max(REPEAT_DELAY, REPEAT_RATE))`.
  - If `held` = 0 in any state: go to IDLE and clear `fcnt`. This has priority over `frame_start`.
  - IDLE → ARMED when `held` = 1.
  - ARMED, on `frame_start`: issue a move, clear `fcnt`, go to DELAY.
  - DELAY, on `frame_start`:
    - If `fcnt` = `REPEAT_DELAY`-1: issue a move, clear `fcnt`, go to REPEAT.
    - Otherwise increment `fcnt`.
  - REPEAT, on `frame_start`:
    - If `fcnt` = `REPEAT_RATE`-1: issue a move and clear `fcnt`.
    - Otherwise increment `fcnt`.
- **Issue:** select one direction among the stable-pressed bits by round-robin.
  - The search starts at the bit after `last_dir` and wraps 3 → 0.
  - `last_dir` updates to the selected bit.
  - `motion` = selected bit index + 1.
- **Opposite directions held together** (up+down, left+right) alternate through the round-robin. They are not cancelled.
- `motion` is nonzero for exactly one cycle per issue and is 000 otherwise. The sprite controller moves once per nonzero cycle, so multi-cycle pulses are forbidden.

## Timing
- **Reset values:**
  - `motion` = 000
  - state = IDLE
  - `fcnt` = 0
  - all debounce counters = 0
  - stable bits = 0
  - sync flops = 0
  - `last_dir` = 3, so the first grant goes to up.
- **Press to stable:** 2 sync cycles plus `DEBOUNCE_CYC` cycles.
- **Issue latency:** `motion` is asserted in the cycle after the `frame_start` that triggers it, for 1 cycle.
- A `frame_start` in the same cycle that `held` first rises is ignored, because the FSM is still in IDLE. The first move comes on the next frame.
- A `frame_start` in the same cycle that `held` falls issues nothing.
- **Press and repeat timing:** with a held press, moves occur on frames N, N+`REPEAT_DELAY`, then every `REPEAT_RATE` frames after that.
- **Changing the pressed set while held** keeps the repeat cadence. It does not restart DELAY. The grant follows the new set.
- **Reset mid-operation:** all state returns to reset values immediately. A `motion` pulse in flight is cut to 000.
- `REPEAT_DELAY` and `REPEAT_RATE` must be ≥ 1. A value of 1 means every frame.

## Structure
- Package `motion_pkg` holds:
  - the `state_t` enum (IDLE, ARMED, DELAY, REPEAT);
  - localparams `MOT_NONE`, `MOT_UP`, `MOT_RIGHT`, `MOT_DOWN`, `MOT_LEFT`, which are shared with the sprite controller;
  - the direction bit indices.
- Sub-module `debouncer` holds one synchronizer plus counter per bit, parameterized by `DEBOUNCE_CYC`. It is instantiated 4× via generate.
- The arbiter and FSM live in `motion_scheduler`.

## Test plan
All scenarios use `DEBOUNCE_CYC`=4, `REPEAT_DELAY`=3, `REPEAT_RATE`=2, and `frame_start` every 20 cycles.

- **Reset:** assert reset mid-pulse → `motion` = 000 asynchronously. Release reset with no buttons pressed for 200 cycles → `motion` stays 000.
- **Bounce:** `btn[0]` toggles every 2 cycles for 30 cycles, then stays low → no `motion` ever.
- **Single held press:** `btn[1]` held steady → `motion` = 010 for 1 cycle after the first `frame_start` following stable. It repeats after 3 frames, then every 2 frames. Releasing returns to 000 with no further pulses.
- **Round-robin:** `btn[0]` and `btn[2]` held together → successive issues are 001, 011, 001, 011.
- **Boundary:** `btn` becomes stable in the same cycle as `frame_start` → no issue on that frame, 001 issued on the next frame. Release in the same cycle as `frame_start` → no issue.
- **Set change while held:** switch `btn[3]` → `btn[1]` (overlap ≥ `DEBOUNCE_CYC`) during REPEAT → cadence unchanged and the next issue is 010.
